ahb_sram_slave: RTL and testbench
=================================

// Module: ahb_sram_slave
// PURPOSE
//  AHB-Lite responder backed by a word-addressed register-array SRAM. It is the
//  target end for the team's AHB master, honouring pipelined address/data phases.
//  Wait states are programmable, and a two-cycle ERROR response flags illegal
//  accesses. Sits behind the address decoder (HSEL) on the shared AHB bus.
// PARAMETERS
//  AW           6   word-index width; memory depth = 2**AW 32-bit words
//  WAIT_STATES  0   HREADYOUT-low cycles inserted per OKAY data phase (0..15)
// PORTS
//  HCLK       in   1   bus clock, all logic on rising edge
//  HRESETn    in   1   asynchronous, active-low reset
//  HSEL       in   1   slave select from decoder
//  HADDR      in   32  byte address (address phase)
//  HTRANS     in   2   00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//  HWRITE     in   1   1 = write, 0 = read
//  HSIZE      in   3   only 3'b010 (word) legal
//  HBURST     in   3   accepted, ignored (master supplies every beat address)
//  HWDATA     in   32  write data (data phase)
//  HREADY     in   1   bus-wide ready; qualifies address-phase sampling
//  HREADYOUT  out  1   this slave's data-phase ready
//  HRESP      out  1   0 OKAY, 1 ERROR
//  HRDATA     out  32  read data, valid when HREADYOUT=1 in a read data phase
//  xfer_count out  16  completed OKAY transfers, wraps 0xFFFF->0
//  err_count  out  8   ERROR responses issued, saturates at 255
// BEHAVIOUR
//  Reset: HREADYOUT=1, HRESP=0, HRDATA=0, counters=0, FSM=S_IDLE. Memory is not
//   reset. Reset mid-transfer aborts it; any pending write is dropped.
//  Accept: on the rising edge with HSEL & HREADY & HTRANS[1], latch addr_q=HADDR[AW+1:2],
//   write_q, and err_q. err_q = (HADDR[31:AW+2]!=0) | (HADDR[1:0]!=0) | (HSIZE!=3'b010).
//   IDLE/BUSY or !HSEL: no data phase; OKAY, HREADYOUT=1, zero wait.
//  FSM states: S_IDLE (no pending phase, or zero-wait completion), S_WAIT, S_ERR1, S_ERR2.
//   accept & err_q        -> S_ERR1: HREADYOUT=0, HRESP=1
//   S_ERR1                -> S_ERR2: HREADYOUT=1, HRESP=1, err_count++
//   accept & WAIT_STATES>0 -> S_WAIT, wait counter loaded with WAIT_STATES
//   S_WAIT: HREADYOUT=0 while counter!=0; decrement each cycle; at 0 HREADYOUT=1 (complete)
//   WAIT_STATES=0: data phase completes in the cycle after accept.
//   S_ERR2 or completion with new accept: start the next phase directly (back-to-back).
//   Otherwise return to S_IDLE.
//  Completion (HREADYOUT=1, OKAY): write -> mem[addr_q]<=HWDATA at that edge;
//   read -> HRDATA=mem[addr_q] combinational, 0 otherwise; xfer_count++.
//  Error phases never write memory; HRDATA=0 during them.
//  Read following a write to the same word returns the new data (write commits at the
//   end of the prior data phase).
//  Address phase sampled during our own S_WAIT is ignored (HREADY=0 on bus).
//  HRESP=1 only in S_ERR1/S_ERR2; HREADYOUT=0 never coincides with an OKAY completion.
// TESTING
//  1 WAIT_STATES=0, write 0xDEADBEEF @0x10, then read @0x10 -> HREADYOUT stays 1,
//    HRDATA=0xDEADBEEF, xfer_count=2
//  2 WAIT_STATES=2, read @0x04 -> HREADYOUT 0,0,1 in data phase; data valid on third cycle
//  3 Access @0x100 with AW=6 -> HRESP=1 for 2 cycles, HREADYOUT 0 then 1, err_count=1,
//    memory unchanged
//  4 Pipelined 4-beat INCR write 0x0,0x4,0x8,0xC, then 4 reads -> data matches, one beat
//    per cycle at zero wait
//  5 HSIZE=3'b000 or HADDR=0x2 -> ERROR; 256 errors -> err_count holds 255
//  6 Assert HRESETn=0 during S_WAIT of a write -> outputs return to reset values,
//    target word not written

Source files
------------

// File: rtl/ahb_sram_slave.sv
// AHB-Lite responder backed by a word-addressed register-array SRAM.
// Supports programmable OKAY wait states and a two-cycle ERROR response for illegal accesses.
module ahb_sram_slave #(
  parameter int unsigned AW          = 6,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic        HRESP,
  output logic [31:0] HRDATA,
  output logic [15:0] xfer_count,
  output logic [7:0]  err_count
);

  localparam int unsigned DEPTH = 2**AW;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  logic [31:0]   mem [DEPTH];
  state_t        state_q, state_d;
  logic [AW-1:0] addr_q;
  logic          write_q;
  logic          active_q, active_d;
  logic [3:0]    wcnt_q, wcnt_d;
  logic          accept, addr_err, complete, hreadyout_c;
  logic          unused;

  // Burst type and the SEQ/NONSEQ distinction carry no information for this slave.
  assign unused = ^{HBURST, HTRANS[0]};

  always_comb begin
    hreadyout_c = 1'b1;
    unique case (state_q)
      S_ERR1:  hreadyout_c = 1'b0;
      S_WAIT:  hreadyout_c = (wcnt_q == 4'd0);
      default: hreadyout_c = 1'b1;
    endcase
  end

  // Address phases are only taken while our own data phase is not stalling the bus.
  assign accept   = HSEL & HREADY & HTRANS[1] & hreadyout_c;
  assign addr_err = (HADDR[31:AW+2] != '0) | (HADDR[1:0] != 2'b00) | (HSIZE != 3'b010);
  assign complete = ((state_q == S_IDLE) && active_q) ||
                    ((state_q == S_WAIT) && (wcnt_q == 4'd0));

  always_comb begin
    state_d  = S_IDLE;
    active_d = 1'b0;
    wcnt_d   = wcnt_q;
    if (state_q == S_ERR1) begin
      state_d = S_ERR2;
    end else if ((state_q == S_WAIT) && (wcnt_q != 4'd0)) begin
      state_d = S_WAIT;
      wcnt_d  = wcnt_q - 4'd1;
    end else if (accept) begin
      if (addr_err) begin
        state_d = S_ERR1;
      end else if (WAIT_STATES > 0) begin
        state_d = S_WAIT;
        wcnt_d  = 4'(WAIT_STATES);
      end else begin
        active_d = 1'b1;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= S_IDLE;
      active_q   <= 1'b0;
      wcnt_q     <= '0;
      addr_q     <= '0;
      write_q    <= 1'b0;
      xfer_count <= '0;
      err_count  <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      wcnt_q   <= wcnt_d;
      if (accept) begin
        addr_q  <= HADDR[AW+1:2];
        write_q <= HWRITE;
      end
      if (complete)
        xfer_count <= xfer_count + 16'd1;
      if ((state_q == S_ERR1) && (err_count != 8'hFF))
        err_count <= err_count + 8'd1;
    end
  end

  always_ff @(posedge HCLK) begin
    if (complete && write_q)
      mem[addr_q] <= HWDATA;
  end

  assign HREADYOUT = hreadyout_c;
  assign HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);
  assign HRDATA    = (complete && !write_q) ? mem[addr_q] : '0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: zero-wait instance driven from a vector table,
// two-wait-state instance exercised with hand-written wait and reset sequences.
module tb_ahb_sram_slave;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        sel0, sel2;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic        rdy0, resp0, rdy2, resp2;
  logic [31:0] rdata0, rdata2;
  logic [15:0] xfer0, xfer2;
  logic [7:0]  err0, err2;

  int total = 0;
  int bad   = 0;

  always #5 HCLK = ~HCLK;

  ahb_sram_slave #(.AW(6), .WAIT_STATES(0)) dut0 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(sel0), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(rdy0),
    .HREADYOUT(rdy0), .HRESP(resp0), .HRDATA(rdata0), .xfer_count(xfer0), .err_count(err0)
  );

  ahb_sram_slave #(.AW(6), .WAIT_STATES(2)) dut2 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(sel2), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA), .HREADY(rdy2),
    .HREADYOUT(rdy2), .HRESP(resp2), .HRDATA(rdata2), .xfer_count(xfer2), .err_count(err2)
  );

  typedef struct {
    logic [1:0]  trans;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_rdy;
    logic        exp_resp;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[23];

  localparam logic [1:0] IDLE = 2'b00, NSEQ = 2'b10, SEQ = 2'b11;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drive(input logic [1:0] t, input logic w, input logic [2:0] s,
                       input logic [31:0] a, input logic [31:0] d);
    HTRANS = t; HWRITE = w; HSIZE = s; HADDR = a; HWDATA = d;
  endtask

  initial begin
    HRESETn = 1'b0; sel0 = 1'b0; sel2 = 1'b0; HBURST = 3'b001;
    drive(IDLE, 1'b0, 3'b010, 32'h0, 32'h0);

    //            trans wr size    addr        wdata         rdy   resp  rdata
    vecs[0]  = '{NSEQ, 1, 3'b010, 32'h10,  32'h0,         1'b1, 1'b0, 32'h0};
    vecs[1]  = '{NSEQ, 0, 3'b010, 32'h10,  32'hDEADBEEF,  1'b1, 1'b0, 32'h0};
    vecs[2]  = '{IDLE, 0, 3'b010, 32'h0,   32'h0,         1'b1, 1'b0, 32'hDEADBEEF};
    vecs[3]  = '{NSEQ, 1, 3'b010, 32'h0,   32'h0,         1'b1, 1'b0, 32'h0};
    vecs[4]  = '{SEQ,  1, 3'b010, 32'h4,   32'h11111111,  1'b1, 1'b0, 32'h0};
    vecs[5]  = '{SEQ,  1, 3'b010, 32'h8,   32'h22222222,  1'b1, 1'b0, 32'h0};
    vecs[6]  = '{SEQ,  1, 3'b010, 32'hC,   32'h33333333,  1'b1, 1'b0, 32'h0};
    vecs[7]  = '{NSEQ, 0, 3'b010, 32'h0,   32'h44444444,  1'b1, 1'b0, 32'h0};
    vecs[8]  = '{SEQ,  0, 3'b010, 32'h4,   32'h0,         1'b1, 1'b0, 32'h11111111};
    vecs[9]  = '{SEQ,  0, 3'b010, 32'h8,   32'h0,         1'b1, 1'b0, 32'h22222222};
    vecs[10] = '{SEQ,  0, 3'b010, 32'hC,   32'h0,         1'b1, 1'b0, 32'h33333333};
    vecs[11] = '{IDLE, 0, 3'b010, 32'h0,   32'h0,         1'b1, 1'b0, 32'h44444444};
    vecs[12] = '{NSEQ, 0, 3'b000, 32'h10,  32'h0,         1'b1, 1'b0, 32'h0};
    vecs[13] = '{IDLE, 0, 3'b010, 32'h0,   32'h0,         1'b0, 1'b1, 32'h0};
    vecs[14] = '{IDLE, 0, 3'b010, 32'h0,   32'h0,         1'b1, 1'b1, 32'h0};
    vecs[15] = '{NSEQ, 1, 3'b010, 32'h2,   32'h0,         1'b1, 1'b0, 32'h0};
    vecs[16] = '{IDLE, 0, 3'b010, 32'h0,   32'hAAAAAAAA,  1'b0, 1'b1, 32'h0};
    vecs[17] = '{IDLE, 0, 3'b010, 32'h0,   32'h0,         1'b1, 1'b1, 32'h0};
    vecs[18] = '{NSEQ, 1, 3'b010, 32'h100, 32'h0,         1'b1, 1'b0, 32'h0};
    vecs[19] = '{IDLE, 0, 3'b010, 32'h0,   32'hFFFFFFFF,  1'b0, 1'b1, 32'h0};
    vecs[20] = '{NSEQ, 0, 3'b010, 32'h0,   32'hFFFFFFFF,  1'b1, 1'b1, 32'h0};
    vecs[21] = '{IDLE, 0, 3'b010, 32'h0,   32'h0,         1'b1, 1'b0, 32'h11111111};
    vecs[22] = '{IDLE, 0, 3'b010, 32'h0,   32'h0,         1'b1, 1'b0, 32'h0};

    cyc(); cyc();
    check("rst_rdy0", {31'd0, rdy0}, 32'd1);
    check("rst_resp0", {31'd0, resp0}, 32'd0);
    check("rst_rdata0", rdata0, 32'h0);
    check("rst_rdy2", {31'd0, rdy2}, 32'd1);
    check("rst_cnt", {xfer0, err0, err2}, 32'h0);
    HRESETn = 1'b1;

    // Zero-wait instance from the vector table: one address phase per cycle.
    cyc();
    sel0 = 1'b1;
    for (int i = 0; i < 23; i++) begin
      drive(vecs[i].trans, vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata);
      #1;
      check($sformatf("v%0d_rdy", i), {31'd0, rdy0}, {31'd0, vecs[i].exp_rdy});
      check($sformatf("v%0d_resp", i), {31'd0, resp0}, {31'd0, vecs[i].exp_resp});
      check($sformatf("v%0d_rdata", i), rdata0, vecs[i].exp_rdata);
      cyc();
    end
    check("xfer0_after_table", {16'd0, xfer0}, 32'd11);
    check("err0_after_table", {24'd0, err0}, 32'd3);

    // Saturation of the error counter.
    for (int n = 0; n < 260; n++) begin
      drive(NSEQ, 1'b0, 3'b000, 32'h0, 32'h0);
      cyc();
      drive(IDLE, 1'b0, 3'b010, 32'h0, 32'h0);
      cyc(); cyc();
    end
    check("err0_saturated", {24'd0, err0}, 32'd255);
    check("xfer0_no_err_count", {16'd0, xfer0}, 32'd11);
    sel0 = 1'b0;

    // Two wait states: write 0x04, then read it back.
    sel2 = 1'b1;
    drive(NSEQ, 1'b1, 3'b010, 32'h4, 32'h0);
    cyc();
    drive(IDLE, 1'b0, 3'b010, 32'h0, 32'hCAFEF00D);
    #1 check("ws_wr_c1_rdy", {31'd0, rdy2}, 32'd0);
    cyc();
    check("ws_wr_c2_rdy", {31'd0, rdy2}, 32'd0);
    cyc();
    check("ws_wr_c3_rdy", {31'd0, rdy2}, 32'd1);
    cyc();
    drive(NSEQ, 1'b0, 3'b010, 32'h4, 32'h0);
    cyc();
    drive(NSEQ, 1'b1, 3'b010, 32'h8, 32'h0);  // ignored: bus stalled by our wait
    #1 check("ws_rd_c1_rdy", {31'd0, rdy2}, 32'd0);
    check("ws_rd_c1_rdata", rdata2, 32'h0);
    cyc();
    drive(IDLE, 1'b0, 3'b010, 32'h0, 32'h0);
    #1 check("ws_rd_c2_rdy", {31'd0, rdy2}, 32'd0);
    cyc();
    check("ws_rd_c3_rdy", {31'd0, rdy2}, 32'd1);
    check("ws_rd_c3_rdata", rdata2, 32'hCAFEF00D);
    check("ws_rd_c3_resp", {31'd0, resp2}, 32'd0);
    cyc();
    check("ws_after_rdy", {31'd0, rdy2}, 32'd1);
    check("xfer2_count", {16'd0, xfer2}, 32'd2);

    // Known value in word 2, then reset in the middle of a waited write to it.
    drive(NSEQ, 1'b1, 3'b010, 32'h8, 32'h0);
    cyc();
    drive(IDLE, 1'b0, 3'b010, 32'h0, 32'h12345678);
    cyc(); cyc(); cyc();
    drive(NSEQ, 1'b1, 3'b010, 32'h8, 32'h0);
    cyc();
    drive(IDLE, 1'b0, 3'b010, 32'h0, 32'h5A5A5A5A);
    cyc();
    HRESETn = 1'b0;
    #1;
    check("midrst_rdy", {31'd0, rdy2}, 32'd1);
    check("midrst_resp", {31'd0, resp2}, 32'd0);
    check("midrst_rdata", rdata2, 32'h0);
    check("midrst_cnt", {xfer2, err2, err0}, 32'h0);
    cyc(); cyc();
    HRESETn = 1'b1;
    drive(NSEQ, 1'b0, 3'b010, 32'h8, 32'h0);
    cyc();
    drive(IDLE, 1'b0, 3'b010, 32'h0, 32'h0);
    cyc(); cyc();
    check("midrst_word_kept_rdy", {31'd0, rdy2}, 32'd1);
    check("midrst_word_kept", rdata2, 32'h12345678);
    cyc();
    check("xfer2_after_rst", {16'd0, xfer2}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
